// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The SERIAL_SUB_OVF_EN macro adds the signed-overflow output.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Bit-counter width for a given operand width.
  function automatic int unsigned cnt_w(int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// Defining SERIAL_SUB_OVF_EN adds the ovf signal.
interface serial_subtractor_if #(
  parameter int unsigned Size = 4
);
  logic            start;
  logic [Size-1:0] a;
  logic [Size-1:0] b;
  logic            bin;
  logic            busy;
  logic            done;
  logic [Size-1:0] diff;
  logic            bout;
`ifdef SERIAL_SUB_OVF_EN
  logic            ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - br, with borrow out.
module serial_fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);

  assign d_o  = a_i ^ b_i ^ br_i;
  assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Defining SERIAL_SUB_OVF_EN adds a signed-overflow flag latched with bout.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned Size = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = cnt_w(Size);
  localparam logic [CntW-1:0] LastCnt = CntW'(Size - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Size-1:0] a_q, a_d;
  logic [Size-1:0] b_q, b_d;
  logic [Size-1:0] diff_q, diff_d;
  logic            br_q, br_d;
  logic            bout_q, bout_d;
  logic            fs_d, fs_br;
`ifdef SERIAL_SUB_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  serial_fs_cell u_fs (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .br_i (br_q),
    .d_o  (fs_d),
    .br_o (fs_br)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          diff_d  = '0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // New bit enters at the MSB so the LSB-first stream lands in place.
        diff_d = (diff_q >> 1) | (Size'(fs_d) << (Size - 1));
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_br;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bout_d  = fs_br;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = br_q ^ fs_br;
`endif
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial signed two's-complement subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Companion to the parallel adder datapath: adder adds in one combinational step; this block performs the inverse operation sequentially with a start/busy/done handshake.
- Sits in the ALU test area as a multi-cycle arithmetic unit driven by a testbench or a controller FSM.

Parameters:
- size, 4, operand and result width in bits (>= 1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  size  signed minuend; captured when start is accepted.
- b  input  size  signed subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  size  signed difference; held until the next accepted start.
- bout  output  1  borrow-out of the MSB stage (1 iff unsigned a < b + bin).
- ovf  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, bit counter=0, internal shift registers=0.
- FSM states and transitions:
  - IDLE: start=1 captures a, b, bin into shift registers, clears diff, sets count=0, next state SHIFT. start=0 stays in IDLE.
  - SHIFT: each edge processes one bit. d = a0^b0^br; br' = (~a0&b0) | (~(a0^b0)&br). d shifts into diff from the MSB end; a and b shift right; count increments. After bit size-1 is processed, latch bout=br', next state DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge E0. busy=1 in cycles 1..size. done=1 in cycle size+1. Total is size+1 cycles from the accepting edge to done.
- Throughput: the next start is accepted no earlier than the cycle after done, one per size+2 cycles.
- start is ignored while in SHIFT or DONE; no queuing.
- a, b and bin may change freely after capture without affecting the result.
- diff and bout hold their final values from the done cycle until the next accepted start. They are cleared on that accepting edge.
- rst mid-operation (SHIFT or DONE) aborts: IDLE next cycle, all outputs per reset values, no done pulse.
- rst and start asserted in the same cycle: rst wins, start is dropped.
- size=1: one SHIFT cycle, done in cycle 2.
- Wrap-around: diff is the result modulo 2^size; no saturation.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined: port ovf exists. ovf = (borrow into MSB stage) XOR (borrow out of MSB stage), latched with bout when leaving SHIFT. It is held alongside diff and cleared by reset and by an accepted start.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - counter width constant CNT_W = $clog2(size+1)
- One natural sub-module: serial_fs_cell, a combinational 1-bit full subtractor (a, b, br -> d, br_out), instantiated once in the datapath.

Test Plan:
- size=4; a=0010, b=1011, bin=0; start pulse at E0 -> busy=1 in cycles 1-4, done=1 in cycle 5 only; diff=0111, bout=1, ovf=0.
- a=1100, b=0011, bin=0 -> diff=1001, bout=0, ovf=0. diff holds 1001 for 10 idle cycles afterwards.
- a=1000, b=0001, bin=0 (-8-1) -> diff=0111, bout=0, ovf=1.
- a=0000, b=0000, bin=1 -> diff=1111, bout=1, ovf=0. A second start asserted during busy is ignored (exactly one done pulse).
- Start a=0110, b=0001; assert rst in cycle 2 -> IDLE in cycle 3, busy=0, diff=0, no done. A fresh start then yields diff=0101, bout=0.
- Random sweep of all 16x16x2 operand combinations against the reference a-b-bin: diff, bout and ovf match every time; done is always exactly size+1 cycles after start.
